// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp: integer register file for the pipelined core.
//   NUM_RD combinational read ports with write-through bypass, one posedge
//   write port, x0 hardwired to zero, per-register busy scoreboard and a
//   soft-clear sequencer that zeroes x1..x(NREGS-1) one register per cycle.
// Ports:
//   clk, rst (async, active low)
//   raddr/rdata/rbusy : packed read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN] / [i]
//   we/waddr/wdata    : writeback port (also clears the busy bit)
//   iss_valid/iss_rd  : issue of an instruction that will write iss_rd (sets busy)
//   clr_req/clr_busy  : soft-clear request / soft clear in progress
//   sb_vec            : full scoreboard vector
module rv_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*$clog2(NREGS)-1:0] raddr,
  output logic [NUM_RD*XLEN-1:0]   rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     iss_valid,
  input  logic [$clog2(NREGS)-1:0] iss_rd,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic [NREGS-1:0]         sb_vec
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                      state_q, state_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic [NREGS-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [NREGS-1:0]            sb_q, sb_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    sb_d    = sb_q;
    case (state_q)
      S_IDLE: begin
        if (we && waddr != '0) begin
          regs_d[waddr] = wdata;
          sb_d[waddr]   = 1'b0;
        end
        // applied after the clear so a same-cycle new producer stays busy
        if (iss_valid && iss_rd != '0) sb_d[iss_rd] = 1'b1;
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = AW'(1);
          sb_d    = '0;
        end
      end
      S_CLEAR: begin
        // writeback and issue are dropped while sweeping
        regs_d[idx_q] = '0;
        if (idx_q == AW'(NREGS-1)) state_d = S_IDLE;
        else                       idx_d   = idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    regs_d[0] = '0;
    sb_d[0]   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= AW'(1);
      regs_q  <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
      sb_q    <= sb_d;
    end
  end

  assign clr_busy = (state_q == S_CLEAR);
  assign sb_vec   = sb_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = raddr[i*AW +: AW];
    assign hit = we && (waddr == ra);
    assign rdata[i*XLEN +: XLEN] = (ra == '0)          ? '0 :
                                   (hit && !clr_busy)  ? wdata :
                                                         regs_q[ra];
    // a same-cycle writeback resolves the hazard
    assign rbusy[i] = !clr_busy && sb_q[ra] && !hit;
  end

endmodule

// File: tb/tb_rv_regfile_mp.sv
module tb_rv_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, NUM_RD = 2, AW = 5;

  logic                     clk, rst;
  logic [NUM_RD*AW-1:0]     raddr;
  logic [NUM_RD*XLEN-1:0]   rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     we, iss_valid, clr_req, clr_busy;
  logic [AW-1:0]            waddr, iss_rd;
  logic [XLEN-1:0]          wdata;
  logic [NREGS-1:0]         sb_vec;

  rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .clr_req(clr_req), .clr_busy(clr_busy), .sb_vec(sb_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // reference model: architectural contents, busy flags, clear progress
  logic [XLEN-1:0] mreg [NREGS];
  bit              mbusy [NREGS];
  int              clr_left, clr_pos;

  task automatic mreset();
    for (int k = 0; k < NREGS; k++) begin mreg[k] = '0; mbusy[k] = 1'b0; end
    clr_left = 0; clr_pos = 1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge rst) mreset();

  always @(posedge clk) begin
    if (!rst) mreset();
    else if (clr_left > 0) begin
      mreg[clr_pos] = '0;
      clr_pos++;
      clr_left--;
    end else begin
      if (we && waddr != 0) begin mreg[waddr] = wdata; mbusy[waddr] = 1'b0; end
      if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
      if (clr_req) begin
        for (int k = 0; k < NREGS; k++) mbusy[k] = 1'b0;
        clr_left = NREGS - 1; clr_pos = 1;
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NREGS-1:0] sbx;
      for (int p = 0; p < NUM_RD; p++) begin
        logic [AW-1:0] ra;
        logic          hit;
        logic [XLEN-1:0] ed;
        logic          eb;
        ra  = raddr[p*AW +: AW];
        hit = we && (waddr == ra);
        if (ra == 0)                      ed = '0;
        else if (clr_left == 0 && hit)    ed = wdata;
        else                              ed = mreg[ra];
        eb = (clr_left == 0) && mbusy[ra] && !hit;
        chk($sformatf("rdata%0d", p), rdata[p*XLEN +: XLEN], ed);
        chk($sformatf("rbusy%0d", p), 32'(rbusy[p]), 32'(eb));
      end
      for (int k = 0; k < NREGS; k++) sbx[k] = mbusy[k];
      chk("sb_vec", sb_vec, sbx);
      chk("clr_busy", 32'(clr_busy), 32'(clr_left > 0));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    we = 0; waddr = 0; wdata = 0; iss_valid = 0; iss_rd = 0; clr_req = 0;
  endtask

  initial begin
    int ccount;
    mreset();
    rst = 1'b0; raddr = '0; idle_in();
    step(); step();
    chk_en = 1'b1;
    rst = 1'b1;

    // 1) all registers read zero after reset
    for (int r = 0; r < NREGS; r++) begin
      raddr = {AW'(NREGS-1-r), AW'(r)};
      @(negedge clk);
      chk("t1_rd0", rdata[31:0], 32'h0);
      chk("t1_rd1", rdata[63:32], 32'h0);
      chk("t1_rbusy", 32'(rbusy), 32'h0);
      step();
    end
    chk("t1_sb", sb_vec, 32'h0);

    // 2) bypass then registered value
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr = {AW'(0), AW'(5)};
    @(negedge clk); chk("t2_bypass", rdata[31:0], 32'hDEADBEEF);
    step(); idle_in();
    @(negedge clk); chk("t2_stored", rdata[31:0], 32'hDEADBEEF);
    step();

    // 3) x0 write discarded
    we = 1; waddr = 0; wdata = 32'h1234; raddr = '0;
    @(negedge clk); chk("t3_x0_same", rdata[31:0], 32'h0);
    step(); idle_in();
    @(negedge clk); chk("t3_x0_after", rdata[31:0], 32'h0);
    chk("t3_sb0", 32'(sb_vec[0]), 32'h0);
    step();

    // 4) scoreboard set / set-wins / clear
    iss_valid = 1; iss_rd = 7;
    step(); idle_in(); raddr = {AW'(0), AW'(7)};
    @(negedge clk); chk("t4_busy", 32'(rbusy[0]), 32'h1);
    we = 1; waddr = 7; wdata = 32'h77; iss_valid = 1; iss_rd = 7;
    step(); idle_in();
    @(negedge clk); chk("t4_setwins", 32'(sb_vec[7]), 32'h1);
    we = 1; waddr = 7; wdata = 32'h78;
    step(); idle_in();
    @(negedge clk); chk("t4_cleared", 32'(sb_vec[7]), 32'h0);
    step();

    // 5) fill, soft clear with writes issued meanwhile
    for (int r = 1; r < NREGS; r++) begin
      we = 1; waddr = AW'(r); wdata = $urandom | 32'h1; iss_valid = 1; iss_rd = AW'(r);
      step();
    end
    idle_in(); clr_req = 1;
    step(); clr_req = 0;
    ccount = 0;
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if (!clr_busy) break;
      ccount++;
      we = 1; waddr = AW'($urandom_range(1, NREGS-1)); wdata = $urandom | 32'h1;
      iss_valid = 1; iss_rd = AW'($urandom_range(1, NREGS-1));
      raddr = AW*NUM_RD'($urandom);
      step();
    end
    idle_in();
    chk("t5_clr_cycles", 32'(ccount), 32'd31);
    for (int r = 1; r < NREGS; r++) begin
      raddr = {AW'(r), AW'(r)};
      @(negedge clk); chk("t5_zero", rdata[31:0], 32'h0);
      step();
    end
    chk("t5_sb", sb_vec, 32'h0);

    // 6) reset aborts a clear in progress
    we = 1; waddr = 20; wdata = 32'hA5A5A5A5;
    step(); idle_in(); clr_req = 1;
    step(); clr_req = 0;
    repeat (9) step();
    raddr = {AW'(0), AW'(20)};
    rst = 1'b0;
    @(negedge clk);
    chk("t6_clr_abort", 32'(clr_busy), 32'h0);
    chk("t6_rd_zero", rdata[31:0], 32'h0);
    step(); step();
    rst = 1'b1;
    we = 1; waddr = 3; wdata = 32'hCAFE0003;
    step(); idle_in(); raddr = {AW'(0), AW'(3)};
    @(negedge clk); chk("t6_wr_x3", rdata[31:0], 32'hCAFE0003);
    step();

    // randomized traffic with occasional soft clears
    for (int c = 0; c < 3000; c++) begin
      we        = 1'($urandom_range(0, 1));
      waddr     = AW'($urandom);
      wdata     = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = AW'($urandom);
      raddr     = AW*NUM_RD'($urandom);
      clr_req   = ($urandom_range(0, 149) == 0);
      step();
    end
    idle_in();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
